// File: rtl/timer_periph_if.sv
// timer_periph_if
// CPU data-bus bundle for the timer/display peripheral.
//
// Handshake: rd and wr are single-cycle strobes with no wait states. A write
// takes effect on the rising edge where wr=1. rdata is combinational from addr
// while rd=1 and is 0 otherwise. The bus never stalls, so there is no ready.
//
// Signals:
//   rd    - read strobe, master -> slave
//   wr    - write strobe, master -> slave
//   addr  - 32-bit byte address, master -> slave
//   wdata - 32-bit write data, master -> slave
//   rdata - 32-bit read data, slave -> master
interface timer_periph_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_periph.sv
// timer_periph
// Memory-mapped reloading 32-bit timer with a level interrupt, an LED register
// and a 7-segment digit register. There is also an optional free-running
// SYSTICK counter, which is enabled by defining TIMER_SYSTICK_EN.
//
// Register map (byte offsets from BASE):
//   0x00 TH (reload, RW)      0x04 TL (counter, RW)
//   0x08 TCON[2:0] (RW)       0x0C LED[7:0] (RW)
//   0x10 SYSTICK (RO)         0x14 DIGI[11:0] (RW)
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - CPU bus (timer_periph_if.slave)
//   led   - LED register
//   digi  - 7-segment register: [6:0] segments (active-low), [7] dp, [11:8] anodes
//   irq   - level interrupt request, TCON[1] & TCON[2]
module timer_periph #(
    parameter logic [31:0] BASE = 32'h4000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_periph_if.slave        bus,
    output logic [7:0]           led,
    output logic [11:0]          digi,
    output logic                 irq
);
    localparam logic [31:0] ADDR_TH      = BASE + 32'h00;
    localparam logic [31:0] ADDR_TL      = BASE + 32'h04;
    localparam logic [31:0] ADDR_TCON    = BASE + 32'h08;
    localparam logic [31:0] ADDR_LED     = BASE + 32'h0C;
    localparam logic [31:0] ADDR_SYSTICK = BASE + 32'h10;
    localparam logic [31:0] ADDR_DIGI    = BASE + 32'h14;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_rd;

    logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic count_step, overflow;

    assign wr_th   = bus.wr && (bus.addr == ADDR_TH);
    assign wr_tl   = bus.wr && (bus.addr == ADDR_TL);
    assign wr_tcon = bus.wr && (bus.addr == ADDR_TCON);
    assign wr_led  = bus.wr && (bus.addr == ADDR_LED);
    assign wr_digi = bus.wr && (bus.addr == ADDR_DIGI);

    // A firmware write to TL overrides the count step for that cycle. Such a
    // write also suppresses any overflow event.
    assign count_step = tcon_q[0] && !wr_tl;
    assign overflow   = count_step && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;

        // Reload uses th_q, so a TH write on the overflow edge does not
        // affect the value reloaded on that edge.
        if (count_step) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        if (wr_tl) begin
            tl_d = bus.wdata;
        end
        if (wr_th) begin
            th_d = bus.wdata;
        end

        if (overflow && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end
        // A TCON write that keeps irq enabled must not drop an overflow
        // event that coincides with it.
        if (wr_tcon) begin
            tcon_d = bus.wdata[2:0];
            if (overflow && bus.wdata[1]) begin
                tcon_d[2] = 1'b1;
            end
        end

        if (wr_led) begin
            led_d = bus.wdata[7:0];
        end
        if (wr_digi) begin
            digi_d = bus.wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick_q, systick_d;

    // Free-running counter that wraps modulo 2^32. Bus writes never touch it.
    always_comb begin
        systick_d = systick_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_d;
        end
    end

    assign systick_rd = systick_q;
`else
    assign systick_rd = '0;
`endif

    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            case (bus.addr)
                ADDR_TH:      bus.rdata = th_q;
                ADDR_TL:      bus.rdata = tl_q;
                ADDR_TCON:    bus.rdata = {29'd0, tcon_q};
                ADDR_LED:     bus.rdata = {24'd0, led_q};
                ADDR_SYSTICK: bus.rdata = systick_rd;
                ADDR_DIGI:    bus.rdata = {20'd0, digi_q};
                default:      bus.rdata = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = tcon_q[1] & tcon_q[2];
endmodule

// File: doc/timer_periph.md
# timer_periph

Memory-mapped timer and display peripheral on the CPU data bus at base 0x40000000. It provides a reloading 32-bit timer with a level interrupt request to the CPU, a LED output register and a 7-segment digit register. It also provides an optional free-running system tick counter. Firmware uses it to time the display-scan interrupt: it programs TH/TL/TCON, services `irq`, clears status and re-arms.

## Interface
Parameters:
- `BASE`, 32'h4000_0000, bus base address; all register offsets are relative to it.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd`  in  1  read strobe (qualifies `rdata`; reads have no side effects).
- `wr`  in  1  write strobe.
- `addr`  in  32  byte address; full 32-bit compare against `BASE`+offset.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`/state when `rd`=1, else 0.
- `led`  out  8  LED register.
- `digi`  out  12  7-segment register: [6:0] segments (active-low), [7] dp, [11:8] anode select.
- `irq`  out  1  interrupt request = TCON[1] & TCON[2].

## Operation
- Register map (offset: name, access):
  - 0x00: TH, reload value, RW.
  - 0x04: TL, counter, RW.
  - 0x08: TCON[2:0], RW; bit0 = count enable, bit1 = irq enable, bit2 = irq status.
  - 0x0C: LED[7:0], RW.
  - 0x10: SYSTICK, RO (see Configuration).
  - 0x14: DIGI[11:0], RW.
- Unmapped address: reads return 0, writes ignored. Reads zero-extend narrow registers.
- Count step, when TCON[0]=1 and no TL write this cycle:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - TL == 32'hFFFF_FFFF (overflow event): TL <= TH; if TCON[1]=1, TCON[2] <= 1.
- TCON[0]=0: TL holds; no overflow events.
- TCON write: TCON <= wdata[2:0]. Firmware clears status by writing back with bit2=0.
- Priority rules:
  - A TL write in the same cycle as a count step: write wins, no increment, no overflow event.
  - A TCON write in the same cycle as an overflow event: written value loads, then bit2 is forced to 1 if wdata[1]=1. The event is never lost while irq is enabled.
  - A TH write in the same cycle as an overflow: TL reloads the old TH.
- `irq` is a level signal, held until firmware clears TCON[2] or TCON[1].

## Timing
- Reset, synchronous and checked first every edge: TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0; hence `led`=0, `digi`=0, `irq`=0, `rdata`=0 when `rd`=0.
- Reset asserted mid-count clears everything on that edge; counting resumes only after firmware rewrites TCON.
- Write latency: a register updates on the edge where `wr`=1; the new value is visible to reads the next cycle.
- Read latency: 0 cycles (combinational). A same-cycle read of a register being written returns the old value.
- First count step occurs on the edge after the edge that writes TCON[0]=1.
- Overflow to `irq` latency: the status bit and `irq` assert on the same edge as the TL reload.
- Reload period with TCON[0]=1: (2^32 − TH) cycles per interrupt; TH=32'hFFFF_FF00 gives 256 cycles.

## Configuration
- `TIMER_SYSTICK_EN` defined: SYSTICK is a 32-bit counter, incremented every cycle after reset and wrapping modulo 2^32. It reads at 0x10; writes to 0x10 are ignored.
- Undefined: no SYSTICK flops; reads at 0x10 return 0.

## Test plan
- Reset: write TH=5, TCON=7, then assert `reset` one cycle -> all registers read 0, `irq`=0, `led`=0, `digi`=0.
- Write TH=32'hFFFF_FF00, TL=32'hFFFF_FFFF, then TCON=3 -> one edge later TL=32'hFFFF_FF00, TCON=7, `irq`=1. The next overflow occurs 256 cycles later.
- Service: with `irq`=1, write TCON=1 then TCON=3 -> `irq` drops after the first write; counting continues uninterrupted; `irq` reasserts at the next overflow.
- Collisions: write TCON=3 on the overflow edge -> TCON reads 7. Write TL=10 on an enabled cycle -> TL=10 then 11 one edge later.
- Write LED=8'hA5 and DIGI=12'h1F9 -> `led`=A5, `digi`=1F9. Write to 0x40000040 -> no state change; read there returns 0.
- With `TIMER_SYSTICK_EN`: two reads of 0x10 taken 100 cycles apart differ by 100. Without it: reads return 0.
